frogger_game_seq: RTL and testbench
===================================

// Module: frogger_game_seq
// PURPOSE
//   Top-level game sequencer for Frogger. Owns the round state machine, lives, score,
//   level and round countdown. Gates movement into frogger_ctrl (o_Move_En), commands
//   frog respawn (o_Frog_Reset) and enables obstacle lanes. o_Level feeds the lane
//   speed logic.
// PARAMETERS
//   CLKS_PER_SEC    25000000  clocks per game second (prescaler terminal count)
//   ROUND_SECS      30        seconds allowed per crossing (max 63)
//   START_LIVES     3         lives at game start (1..3)
//   PAUSE_SECS      2         freeze time after a death or a goal
//   MAX_SCORE       99        score saturation value (max 127)
//   LEVEL_UP_EVERY  5         goals per level increment
// PORTS
//   i_Clk           in   1  system clock
//   i_Rst_L         in   1  async active-low reset
//   i_Start         in   1  start button, debounced, level (edge-detected internally)
//   i_Collided      in   1  frog hit hazard this cycle
//   i_Goal          in   1  frog reached a home slot this cycle
//   o_State         out  3  0 IDLE, 1 PLAY, 2 DYING, 3 SCORED, 4 GAME_OVER
//   o_Move_En       out  1  frog movement allowed
//   o_Obstacle_En   out  1  lanes advance
//   o_Frog_Reset    out  1  1-cycle respawn pulse to frogger_ctrl
//   o_Lives         out  2  remaining lives
//   o_Score         out  7  goals scored, saturating
//   o_Level         out  4  difficulty level, saturating at 15
//   o_Time_Left     out  6  seconds left in current crossing
// BEHAVIOUR
//   Reset (async, i_Rst_L=0): State=IDLE, Lives=START_LIVES, Score=0, Level=0,
//     Time_Left=ROUND_SECS. Move_En, Obstacle_En and Frog_Reset are 0. Prescaler=0,
//     start-edge register=0.
//     Release takes effect on the next i_Clk edge. Reset mid-game discards all state.
//   Start edge: st = i_Start & ~r_Start_d. Holding i_Start gives exactly one event.
//   Prescaler: counts 0..CLKS_PER_SEC-1 only in PLAY/DYING/SCORED; tick = (cnt==max).
//     Cleared to 0 on every state change.
//   All outputs are registered. o_Move_En = (State==PLAY).
//     o_Obstacle_En = State in {IDLE, PLAY, DYING} (IDLE runs attract mode).
//   IDLE / GAME_OVER:
//     On st -> PLAY. Lives=START_LIVES, Score=0, Level=0, Time_Left=ROUND_SECS.
//     All other inputs are ignored.
//   PLAY, evaluated per cycle in priority order:
//     1) i_Collided, or (tick & Time_Left==1): a death.
//        Time_Left becomes 0 on timeout. Lives -= 1.
//        Next state is GAME_OVER if Lives was 1, else DYING.
//     2) i_Goal: Score = min(Score+1, MAX_SCORE).
//        If the new Score is a nonzero multiple of LEVEL_UP_EVERY:
//        Level = min(Level+1, 15). Next state is SCORED.
//     3) tick alone: Time_Left -= 1.
//     Collision and goal in the same cycle count as a death only.
//   DYING / SCORED:
//     Inputs are ignored. Count PAUSE_SECS ticks.
//     On the final tick -> PLAY with Time_Left=ROUND_SECS.
//   o_Frog_Reset is high for exactly the first cycle in which o_State==PLAY
//     (every entry into PLAY). It is never high in any other state.
//   Score does not saturate into Level: at MAX_SCORE, further goals leave Score
//     and Level unchanged but still go to SCORED.
//   Lives never underflows: there is no decrement outside PLAY.
// TESTING (bench params: CLKS_PER_SEC=4, ROUND_SECS=3, PAUSE_SECS=1, LEVEL_UP_EVERY=2)
//   Reset, then hold i_Start high 10 cycles -> a single IDLE->PLAY transition.
//     Frog_Reset is 1 cycle; Lives=3, Time_Left=3.
//   In PLAY, pulse i_Goal twice, each after returning to PLAY -> Score=2, Level=1.
//     Each goal gives SCORED for 4 cycles, then a Frog_Reset pulse.
//   In PLAY, assert i_Collided and i_Goal in the same cycle -> DYING, Lives=2, Score unchanged.
//   Idle in PLAY with no input -> Time_Left 3,2,1 at 4-cycle intervals.
//     Then DYING with Lives-1 and Time_Left=0.
//   Three deaths from Lives=3 -> GAME_OVER, Move_En=0, Obstacle_En=0.
//     i_Collided is then ignored; i_Start edge -> PLAY with Lives=3, Score=0.
//   Drop i_Rst_L mid-DYING -> all outputs reach reset values at once, without a clock edge.

Source files
------------

// File: rtl/frogger_game_seq.sv
// Round sequencer for Frogger: owns the play/death/score state machine, lives,
// score, level and the per-crossing countdown driven by a one-second prescaler.
module frogger_game_seq #(
  parameter int CLKS_PER_SEC   = 25000000,
  parameter int ROUND_SECS     = 30,
  parameter int START_LIVES    = 3,
  parameter int PAUSE_SECS     = 2,
  parameter int MAX_SCORE      = 99,
  parameter int LEVEL_UP_EVERY = 5
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_Start,
  input  logic       i_Collided,
  input  logic       i_Goal,
  output logic [2:0] o_State,
  output logic       o_Move_En,
  output logic       o_Obstacle_En,
  output logic       o_Frog_Reset,
  output logic [1:0] o_Lives,
  output logic [6:0] o_Score,
  output logic [3:0] o_Level,
  output logic [5:0] o_Time_Left
);

  localparam int CW = (CLKS_PER_SEC > 1) ? $clog2(CLKS_PER_SEC) : 1;
  localparam int PW = (PAUSE_SECS > 1) ? $clog2(PAUSE_SECS) : 1;
  localparam int GW = (LEVEL_UP_EVERY > 1) ? $clog2(LEVEL_UP_EVERY) : 1;

  localparam logic [CW-1:0] PRESC_LAST = CW'(CLKS_PER_SEC - 1);
  localparam logic [PW-1:0] PAUSE_LAST = PW'(PAUSE_SECS - 1);
  localparam logic [GW-1:0] GOAL_LAST  = GW'(LEVEL_UP_EVERY - 1);
  localparam logic [6:0]    SCORE_MAX  = 7'(MAX_SCORE);
  localparam logic [5:0]    ROUND_INIT = 6'(ROUND_SECS);
  localparam logic [1:0]    LIVES_INIT = 2'(START_LIVES);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PLAY      = 3'd1,
    DYING     = 3'd2,
    SCORED    = 3'd3,
    GAME_OVER = 3'd4
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] presc, presc_nxt;
  logic [PW-1:0] pause, pause_nxt;
  logic [GW-1:0] goal_cnt, goal_cnt_nxt;
  logic [1:0]    lives, lives_nxt;
  logic [6:0]    score, score_nxt;
  logic [3:0]    level, level_nxt;
  logic [5:0]    time_left, time_left_nxt;
  logic          start_d;
  logic          move_en, obstacle_en, frog_reset;
  logic          st, counting, tick, timeout;

  function automatic logic [6:0] sat_inc_score(input logic [6:0] s);
    return (s >= SCORE_MAX) ? s : s + 7'd1;
  endfunction

  function automatic logic [3:0] sat_inc_level(input logic [3:0] l);
    return (l == 4'd15) ? l : l + 4'd1;
  endfunction

  always_comb begin
    st            = i_Start && !start_d;
    counting      = (state == PLAY) || (state == DYING) || (state == SCORED);
    tick          = counting && (presc == PRESC_LAST);
    timeout       = tick && (time_left == 6'd1);
    state_nxt     = state;
    lives_nxt     = lives;
    score_nxt     = score;
    level_nxt     = level;
    time_left_nxt = time_left;
    goal_cnt_nxt  = goal_cnt;
    pause_nxt     = pause;
    presc_nxt     = '0;

    case (state)
      IDLE, GAME_OVER: begin
        if (st) begin
          state_nxt     = PLAY;
          lives_nxt     = LIVES_INIT;
          score_nxt     = '0;
          level_nxt     = '0;
          goal_cnt_nxt  = '0;
          time_left_nxt = ROUND_INIT;
        end
      end
      PLAY: begin
        // A death outranks a simultaneous goal; a goal outranks the countdown tick.
        if (i_Collided || timeout) begin
          if (timeout) time_left_nxt = '0;
          lives_nxt = lives - 2'd1;
          state_nxt = (lives == 2'd1) ? GAME_OVER : DYING;
        end else if (i_Goal) begin
          state_nxt = SCORED;
          if (score < SCORE_MAX) begin
            score_nxt = sat_inc_score(score);
            if (goal_cnt == GOAL_LAST) begin
              goal_cnt_nxt = '0;
              level_nxt    = sat_inc_level(level);
            end else begin
              goal_cnt_nxt = goal_cnt + GW'(1);
            end
          end
        end else if (tick) begin
          time_left_nxt = time_left - 6'd1;
        end
      end
      DYING, SCORED: begin
        if (tick) begin
          if (pause == PAUSE_LAST) begin
            state_nxt     = PLAY;
            time_left_nxt = ROUND_INIT;
          end else begin
            pause_nxt = pause + PW'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Both timers restart from zero whenever the state changes.
    if (state_nxt != state) begin
      pause_nxt = '0;
    end else if (counting) begin
      presc_nxt = tick ? '0 : presc + CW'(1);
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state       <= IDLE;
      presc       <= '0;
      pause       <= '0;
      goal_cnt    <= '0;
      lives       <= LIVES_INIT;
      score       <= '0;
      level       <= '0;
      time_left   <= ROUND_INIT;
      start_d     <= 1'b0;
      move_en     <= 1'b0;
      obstacle_en <= 1'b0;
      frog_reset  <= 1'b0;
    end else begin
      state       <= state_nxt;
      presc       <= presc_nxt;
      pause       <= pause_nxt;
      goal_cnt    <= goal_cnt_nxt;
      lives       <= lives_nxt;
      score       <= score_nxt;
      level       <= level_nxt;
      time_left   <= time_left_nxt;
      start_d     <= i_Start;
      move_en     <= (state_nxt == PLAY);
      obstacle_en <= (state_nxt == IDLE) || (state_nxt == PLAY) || (state_nxt == DYING);
      frog_reset  <= (state_nxt == PLAY) && (state != PLAY);
    end
  end

  assign o_State       = state;
  assign o_Move_En     = move_en;
  assign o_Obstacle_En = obstacle_en;
  assign o_Frog_Reset  = frog_reset;
  assign o_Lives       = lives;
  assign o_Score       = score;
  assign o_Level       = level;
  assign o_Time_Left   = time_left;

endmodule

// File: tb/tb_frogger_game_seq.sv
// Scoreboard bench for frogger_game_seq: a cycle-level game model predicts every
// output after each clock edge; a monitor compares the DUT against the queue.
module tb_frogger_game_seq;

  localparam int CPS   = 4;
  localparam int ROUND = 3;
  localparam int START = 3;
  localparam int PAUSE = 1;
  localparam int MAXS  = 99;
  localparam int LUE   = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       i_Start = 1'b0;
  logic       i_Collided = 1'b0;
  logic       i_Goal = 1'b0;
  logic [2:0] o_State;
  logic       o_Move_En, o_Obstacle_En, o_Frog_Reset;
  logic [1:0] o_Lives;
  logic [6:0] o_Score;
  logic [3:0] o_Level;
  logic [5:0] o_Time_Left;

  frogger_game_seq #(
    .CLKS_PER_SEC(CPS), .ROUND_SECS(ROUND), .START_LIVES(START),
    .PAUSE_SECS(PAUSE), .MAX_SCORE(MAXS), .LEVEL_UP_EVERY(LUE)
  ) dut (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_Start(i_Start), .i_Collided(i_Collided),
    .i_Goal(i_Goal), .o_State(o_State), .o_Move_En(o_Move_En),
    .o_Obstacle_En(o_Obstacle_En), .o_Frog_Reset(o_Frog_Reset), .o_Lives(o_Lives),
    .o_Score(o_Score), .o_Level(o_Level), .o_Time_Left(o_Time_Left)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] state;
    logic       move_en;
    logic       obst;
    logic       frog;
    logic [1:0] lives;
    logic [6:0] score;
    logic [3:0] level;
    logic [5:0] tl;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  // Game model: 0 IDLE, 1 PLAY, 2 DYING, 3 SCORED, 4 GAME_OVER.
  // Seconds are derived from the number of cycles spent in the current state.
  int m_state, m_lives, m_score, m_level, m_tl, m_age;
  bit m_start_d;

  task automatic model_reset();
    m_state = 0; m_lives = START; m_score = 0; m_level = 0; m_tl = ROUND;
    m_age = 0; m_start_d = 1'b0;
  endtask

  task automatic model_step(input bit s, input bit c, input bit g);
    int   prev;
    bit   st, tick, tout;
    exp_t e;
    st = s && !m_start_d;
    m_start_d = s;
    prev = m_state;
    tick = (m_state >= 1 && m_state <= 3) && ((m_age + 1) % CPS == 0);
    case (m_state)
      0, 4: if (st) begin
        m_state = 1; m_lives = START; m_score = 0; m_level = 0; m_tl = ROUND;
      end
      1: begin
        tout = tick && (m_tl == 1);
        if (c || tout) begin
          if (tout) m_tl = 0;
          m_lives = m_lives - 1;
          m_state = (m_lives == 0) ? 4 : 2;
        end else if (g) begin
          if (m_score < MAXS) begin
            m_score = m_score + 1;
            if (m_score % LUE == 0) m_level = (m_level < 15) ? m_level + 1 : 15;
          end
          m_state = 3;
        end else if (tick) begin
          m_tl = m_tl - 1;
        end
      end
      default: if (tick && (m_age + 1) == PAUSE * CPS) begin
        m_state = 1; m_tl = ROUND;
      end
    endcase
    m_age = (m_state != prev) ? 0 : m_age + 1;
    e.state   = 3'(m_state);
    e.move_en = (m_state == 1);
    e.obst    = (m_state <= 2);
    e.frog    = (m_state == 1) && (prev != 1);
    e.lives   = 2'(m_lives);
    e.score   = 7'(m_score);
    e.level   = 4'(m_level);
    e.tl      = 6'(m_tl);
    sb.push_back(e);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic chk_reset_values();
    chk("rst_state", int'(o_State), 0);
    chk("rst_move_en", int'(o_Move_En), 0);
    chk("rst_obstacle_en", int'(o_Obstacle_En), 0);
    chk("rst_frog_reset", int'(o_Frog_Reset), 0);
    chk("rst_lives", int'(o_Lives), START);
    chk("rst_score", int'(o_Score), 0);
    chk("rst_level", int'(o_Level), 0);
    chk("rst_time_left", int'(o_Time_Left), ROUND);
  endtask

  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("state", int'(o_State), int'(e.state));
      chk("move_en", int'(o_Move_En), int'(e.move_en));
      chk("obstacle_en", int'(o_Obstacle_En), int'(e.obst));
      chk("frog_reset", int'(o_Frog_Reset), int'(e.frog));
      chk("lives", int'(o_Lives), int'(e.lives));
      chk("score", int'(o_Score), int'(e.score));
      chk("level", int'(o_Level), int'(e.level));
      chk("time_left", int'(o_Time_Left), int'(e.tl));
    end
  end

  task automatic drive(input bit s, input bit c, input bit g);
    i_Start = s; i_Collided = c; i_Goal = g;
    model_step(s, c, g);
  endtask

  task automatic cyc(input bit s, input bit c, input bit g);
    @(negedge clk);
    drive(s, c, g);
  endtask

  task automatic wait_play();
    for (int i = 0; i < 40 && m_state != 1; i++) cyc(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    #1 rst_n = 1'b0;
    #2 chk_reset_values();
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 1'b0);

    // Held start button gives one transition into PLAY.
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 2; i++) begin
      wait_play();
      cyc(1'b0, 1'b0, 1'b1);
    end
    wait_play();
    cyc(1'b0, 1'b1, 1'b1);

    // Countdown runs out with no input.
    wait_play();
    for (int i = 0; i < 14; i++) cyc(1'b0, 1'b0, 1'b0);

    wait_play();
    cyc(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'b1);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);

    // Enough goals to saturate both level and score.
    for (int g = 0; g < 105; g++) begin
      wait_play();
      cyc(1'b0, 1'b0, 1'b1);
    end

    // Asynchronous reset while dying.
    wait_play();
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_reset_values();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(0, 11) == 0, $urandom_range(0, 19) == 0, $urandom_range(0, 7) == 0);

    cyc(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
